// File: rtl/hazard_pkg.sv
// Shared encodings for the load-use stall controller: forwarding selects, FSM states, select priority.
// Pure definitions: no latency, no flow control.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10
    } state_e;

    // Youngest producer wins; a load in EX is never a forwarding source.
    function automatic logic [1:0] fwd_pick(input logic m_ex_alu, input logic m_mem, input logic m_wb);
        if (m_ex_alu)
            return FWD_EXMEM;
        else if (m_mem)
            return FWD_MEMWB;
        else if (m_wb)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/load_use_stall_ctrl_if.sv
// ID/EX hazard bus: pipeline-stage register info in, stall/bubble/freeze/forward controls out.
// Combinational controls plus registered fwd_sel; the pipeline obeys freeze/stall, no handshake.
interface load_use_stall_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_reg_write;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_reg_write;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_reg_write;
    logic                      dmem_busy;
    logic                      stall_front;
    logic                      bubble;
    logic                      freeze;
    logic [NUM_SRC*2-1:0]      fwd_sel;

    modport master (
        output id_rs, id_rs_used, ex_rd, ex_reg_write, ex_is_load,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_busy,
        input  stall_front, bubble, freeze, fwd_sel
    );

    modport slave (
        input  id_rs, id_rs_used, ex_rd, ex_reg_write, ex_is_load,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_busy,
        output stall_front, bubble, freeze, fwd_sel
    );
endinterface

// File: rtl/load_use_stall_ctrl_src_match.sv
// Per-operand comparator of one ID source register against the EX/MEM/WB destinations.
// Purely combinational, zero latency, no flow control.
module src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic              match_ex,
    output logic              match_mem,
    output logic              match_wb
);
    logic live;

    // x0 is hardwired zero, so it never depends on an in-flight write.
    assign live      = rs_used && (rs != '0);
    assign match_ex  = live && ex_we  && (ex_rd  == rs);
    assign match_mem = live && mem_we && (mem_rd == rs);
    assign match_wb  = live && wb_we  && (wb_rd  == rs);

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Load-use stall / freeze / forwarding controller beside ID/EX: stall_front, bubble, freeze same-cycle;
// fwd_sel registered, valid while the instruction sits in EX; dmem_busy freezes everything and holds all state.
module load_use_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    load_use_stall_ctrl_if.slave  bus
);
    localparam logic [1:0] S_RUN        = ST_RUN;
    localparam logic [1:0] S_LOAD_STALL = ST_LOAD_STALL;
    localparam logic [1:0] S_MEM_WAIT   = ST_MEM_WAIT;
    localparam logic [1:0] CNT_INIT     = 2'(LOAD_LAT - 1);

    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_mem;
    logic [NUM_SRC-1:0]   match_wb;

    logic [1:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 ret_q, ret_d;
    logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;

    logic [1:0]           eff_state;
    logic                 load_hazard;
    logic                 stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_match #(.REG_AW(REG_AW)) u_src_match (
            .rs        (bus.id_rs[i*REG_AW +: REG_AW]),
            .rs_used   (bus.id_rs_used[i]),
            .ex_rd     (bus.ex_rd),
            .ex_we     (bus.ex_reg_write),
            .mem_rd    (bus.mem_rd),
            .mem_we    (bus.mem_reg_write),
            .wb_rd     (bus.wb_rd),
            .wb_we     (bus.wb_reg_write),
            .match_ex  (match_ex[i]),
            .match_mem (match_mem[i]),
            .match_wb  (match_wb[i])
        );
    end

    assign load_hazard = bus.ex_is_load && (|match_ex);

    // MEM_WAIT only marks "frozen"; the first unfrozen cycle acts as the saved state.
    assign eff_state = (state_q == S_MEM_WAIT) ? (ret_q ? S_LOAD_STALL : S_RUN) : state_q;

    assign stall = !bus.dmem_busy &&
                   (((eff_state == S_RUN) && load_hazard) || (eff_state == S_LOAD_STALL));

    assign bus.freeze      = bus.dmem_busy;
    assign bus.stall_front = stall;
    assign bus.bubble      = stall;
    assign bus.fwd_sel     = fwd_sel_q;

    // cnt holds the bubbles still owed, counting the current LOAD_STALL cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        if (bus.dmem_busy) begin
            if (state_q != S_MEM_WAIT) begin
                ret_d   = (state_q == S_LOAD_STALL);
                state_d = S_MEM_WAIT;
            end
        end else begin
            ret_d = 1'b0;
            case (eff_state)
                S_RUN: begin
                    state_d = S_RUN;
                    if (load_hazard && (CNT_INIT != 2'd0)) begin
                        state_d = S_LOAD_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_LOAD_STALL: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = S_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = S_LOAD_STALL;
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_sel_d = fwd_sel_q;
        if (!bus.dmem_busy) begin
            if (stall) begin
                fwd_sel_d = '0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    fwd_sel_d[i*2 +: 2] = fwd_pick(match_ex[i] && !bus.ex_is_load,
                                                   match_mem[i], match_wb[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            cnt_q     <= 2'd0;
            ret_q     <= 1'b0;
            fwd_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ret_q     <= ret_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench: LOAD_LAT=1 and LOAD_LAT=2 controllers share one directed stimulus stream;
// expected {stall_front,bubble,freeze,fwd_sel} per cycle are queued and checked by a monitor.
module tb_load_use_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write, dmem_busy;

    always #5 clk = ~clk;

    load_use_stall_ctrl_if #(.NUM_SRC(2), .REG_AW(5)) if1 ();
    load_use_stall_ctrl_if #(.NUM_SRC(2), .REG_AW(5)) if2 ();

    assign if1.id_rs         = id_rs;
    assign if1.id_rs_used    = id_rs_used;
    assign if1.ex_rd         = ex_rd;
    assign if1.ex_reg_write  = ex_reg_write;
    assign if1.ex_is_load    = ex_is_load;
    assign if1.mem_rd        = mem_rd;
    assign if1.mem_reg_write = mem_reg_write;
    assign if1.wb_rd         = wb_rd;
    assign if1.wb_reg_write  = wb_reg_write;
    assign if1.dmem_busy     = dmem_busy;

    assign if2.id_rs         = id_rs;
    assign if2.id_rs_used    = id_rs_used;
    assign if2.ex_rd         = ex_rd;
    assign if2.ex_reg_write  = ex_reg_write;
    assign if2.ex_is_load    = ex_is_load;
    assign if2.mem_rd        = mem_rd;
    assign if2.mem_reg_write = mem_reg_write;
    assign if2.wb_rd         = wb_rd;
    assign if2.wb_reg_write  = wb_reg_write;
    assign if2.dmem_busy     = dmem_busy;

    load_use_stall_ctrl #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1)) u_lat1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    load_use_stall_ctrl #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(2)) u_lat2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    typedef struct {
        int         idx;
        logic [6:0] e1;
        logic [6:0] e2;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [6:0] act1, act2;
    int         checks = 0;
    int         errors = 0;
    int         vec    = 0;

    // Expected words are written {stall, freeze, fwd[3:0]}; bubble must equal stall.
    task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
                       input logic [4:0] erd, input logic ewe, input logic eld,
                       input logic [4:0] mrd, input logic mwe, input logic [4:0] wrd, input logic wwe,
                       input logic busy, input logic [5:0] e1, input logic [5:0] e2);
        exp_t x;
        @(posedge clk);
        #1;
        reset         = r;
        id_rs         = {rs2, rs1};
        id_rs_used    = used;
        ex_rd         = erd;
        ex_reg_write  = ewe;
        ex_is_load    = eld;
        mem_rd        = mrd;
        mem_reg_write = mwe;
        wb_rd         = wrd;
        wb_reg_write  = wwe;
        dmem_busy     = busy;
        x.idx = vec;
        x.e1  = {e1[5], e1[5], e1[4], e1[3:0]};
        x.e2  = {e2[5], e2[5], e2[4], e2[3:0]};
        sb.push_back(x);
        vec++;
    endtask

    task automatic idle(input logic [5:0] e1, input logic [5:0] e2);
        cyc(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, e1, e2);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur  = sb.pop_front();
            act1 = {if1.stall_front, if1.bubble, if1.freeze, if1.fwd_sel};
            act2 = {if2.stall_front, if2.bubble, if2.freeze, if2.fwd_sel};
            checks++;
            if (act1 !== cur.e1) begin
                errors++;
                $display("FAIL vec%0d lat1 {stall,bubble,freeze,fwd}: got %b expected %b", cur.idx, act1, cur.e1);
            end
            checks++;
            if (act2 !== cur.e2) begin
                errors++;
                $display("FAIL vec%0d lat2 {stall,bubble,freeze,fwd}: got %b expected %b", cur.idx, act2, cur.e2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; id_rs = '0; id_rs_used = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0; dmem_busy = 1'b0;

        // reset state
        cyc(1'b0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        // load x5 -> rs1=x5, LOAD_LAT=1 flow
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        cyc(1'b1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 5, 1, 0, 6'b00_0010, 6'b00_0000);
        idle(6'b00_0000, 6'b00_0000);
        // load x5 -> rs1=x5, LOAD_LAT=2 flow
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 5, 1, 0, 6'b00_0010, 6'b00_0000);
        cyc(1'b1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 0, 6'b00_0011, 6'b00_0011);
        idle(6'b00_0000, 6'b00_0000);
        // x0 never matches
        cyc(1'b1, 0, 0, 2'b01, 0, 1, 1, 0, 1, 0, 1, 0, 6'b00_0000, 6'b00_0000);
        idle(6'b00_0000, 6'b00_0000);
        // ALU forwarding and ex>mem>wb priority
        cyc(1'b1, 0, 7, 2'b10, 7, 1, 0, 7, 1, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        cyc(1'b1, 9, 4, 2'b11, 3, 1, 0, 9, 1, 4, 1, 0, 6'b00_0100, 6'b00_0100);
        idle(6'b00_1110, 6'b00_1110);
        idle(6'b00_0000, 6'b00_0000);
        // dmem_busy for 3 cycles after the first bubble
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 1, 6'b01_0000, 6'b01_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 1, 6'b01_0000, 6'b01_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 1, 6'b01_0000, 6'b01_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 5, 1, 0, 6'b00_0010, 6'b00_0000);
        idle(6'b00_0011, 6'b00_0011);
        idle(6'b00_0000, 6'b00_0000);
        // freeze and load hazard together: freeze wins, stall resumes afterwards
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 1, 6'b01_0000, 6'b01_0000);
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        idle(6'b00_0010, 6'b00_0000);
        idle(6'b00_0000, 6'b00_0000);
        // back-to-back load hazard on the release cycle
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        cyc(1'b1, 0, 8, 2'b10, 8, 1, 1, 0, 0, 5, 1, 0, 6'b10_0010, 6'b10_0000);
        cyc(1'b1, 0, 8, 2'b10, 0, 0, 0, 8, 1, 0, 0, 0, 6'b00_0000, 6'b10_0000);
        cyc(1'b1, 0, 8, 2'b10, 0, 0, 0, 0, 0, 8, 1, 0, 6'b00_1000, 6'b00_0000);
        idle(6'b00_1100, 6'b00_1100);
        idle(6'b00_0000, 6'b00_0000);
        // reset clears a non-zero fwd_sel immediately
        cyc(1'b1, 0, 7, 2'b10, 7, 1, 0, 0, 0, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        cyc(1'b0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        idle(6'b00_0000, 6'b00_0000);
        // reset during LOAD_STALL with cnt=1 (LOAD_LAT=2)
        cyc(1'b1, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 6'b10_0000, 6'b10_0000);
        cyc(1'b0, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        cyc(1'b1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 0, 0, 0, 6'b00_0000, 6'b00_0000);
        idle(6'b00_0010, 6'b00_0010);
        idle(6'b00_0000, 6'b00_0000);
        // operands not read: matching addresses are ignored
        cyc(1'b1, 5, 6, 2'b00, 5, 1, 1, 6, 1, 5, 1, 0, 6'b00_0000, 6'b00_0000);
        cyc(1'b1, 5, 6, 2'b00, 5, 1, 0, 6, 1, 5, 1, 0, 6'b00_0000, 6'b00_0000);
        idle(6'b00_0000, 6'b00_0000);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
